// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

   localparam int CLA_WIDTH = 16;
   localparam int CLA_GROUP = 4;

   // Control part of one in-flight operation. The partial sum is appended in
   // the top module because its width follows the WIDTH parameter.
   typedef struct packed {
      logic valid;
      logic carry;
      logic a_msb;
      logic b_msb;
   } stage_ctrl_t;

   // Number of lookahead slices, which is also the number of slice stages.
   function automatic int cla_ngrp(input int width, input int group);
      return (group < 1) ? 1 : width / group;
   endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: every internal carry is a flat
// sum-of-products of generate/propagate terms, so there is no ripple path.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = CLA_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             c_in,
   output logic [GROUP-1:0] sum,
   output logic             c_out,
   output logic             grp_p,
   output logic             grp_g
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP-1:0] c;

   // Carry into bit i = c_in & p[0..i-1]  |  OR_j ( g[j] & p[j+1..i-1] ).
   function automatic logic [GROUP-1:0] carries(input logic [GROUP-1:0] gv,
                                                input logic [GROUP-1:0] pv,
                                                input logic             ci);
      logic [GROUP-1:0] cv;
      logic             term;
      cv = '0;
      for (int i = 0; i < GROUP; i++) begin
         term = ci;
         for (int j = 0; j < i; j++) term = term & pv[j];
         cv[i] = term;
         for (int j = 0; j < i; j++) begin
            term = gv[j];
            for (int m = j + 1; m < i; m++) term = term & pv[m];
            cv[i] = cv[i] | term;
         end
      end
      return cv;
   endfunction

   // Group generate: some bit generates and every bit above it propagates.
   function automatic logic group_gen(input logic [GROUP-1:0] gv,
                                      input logic [GROUP-1:0] pv);
      logic res;
      logic term;
      res = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         term = gv[j];
         for (int m = j + 1; m < GROUP; m++) term = term & pv[m];
         res = res | term;
      end
      return res;
   endfunction

   assign g     = a & b;
   assign p     = a ^ b;
   assign c     = carries(g, p, c_in);
   assign sum   = p ^ c;
   assign grp_p = &p;
   assign grp_g = group_gen(g, p);
   assign c_out = grp_g | (grp_p & c_in);

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Slice k is added in stage k;
// operand bits above it wait in a shrinking skew register, and finished sum
// slices accumulate in the stage record so a whole result leaves together.
module cla_pipe_addsub
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int GROUP = CLA_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NGRP = cla_ngrp(WIDTH, GROUP);

   if (GROUP < 1) begin : g_bad_group
      $error("cla_pipe_addsub: GROUP must be at least 1");
   end else if (WIDTH % GROUP != 0) begin : g_bad_width
      $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
   end

   typedef struct packed {
      stage_ctrl_t      ctl;
      logic [WIDTH-1:0] psum;
   } stage_t;

   logic             en;
   logic [WIDTH-1:0] bb;
   logic             c0;

   // Subtraction is A + ~B + 1; cin is ignored for subtraction.
   assign bb = sub ? ~b : b;
   assign c0 = sub ? 1'b1 : cin;

   // Whole pipe advances together; it only stops when a result is waiting.
   assign en       = !out_valid | out_ready;
   assign in_ready = en & !rst;

   for (genvar k = 0; k < NGRP; k++) begin : stg
      // Operand bits from this slice upward (this slice is the low GROUP).
      localparam int SW = WIDTH - k * GROUP;

      logic [SW-1:0]    src_a;
      logic [SW-1:0]    src_b;
      logic             src_c;
      stage_t           prev;
      stage_t           nxt;
      stage_t           rec;
      logic [GROUP-1:0] gsum;
      logic             gco;
      logic             gp;
      logic             gg;
      logic             unused_pg;

      if (k == 0) begin : g_head
         assign src_a = a;
         assign src_b = bb;
         assign src_c = c0;

         // Fresh record for an incoming beat; operand MSBs ride along for overflow.
         always_comb begin
            prev           = '0;
            prev.ctl.valid = in_valid;
            prev.ctl.a_msb = a[WIDTH-1];
            prev.ctl.b_msb = bb[WIDTH-1];
         end
      end else begin : g_body
         // Skew register: upper operand bits still waiting for their slice.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               src_a <= '0;
               src_b <= '0;
            end else if (en) begin
               src_a <= stg[k-1].src_a[SW+GROUP-1:GROUP];
               src_b <= stg[k-1].src_b[SW+GROUP-1:GROUP];
            end
         end

         assign src_c = stg[k-1].rec.ctl.carry;
         assign prev  = stg[k-1].rec;
      end

      cla_group #(.GROUP(GROUP)) u_grp (
         .a     (src_a[GROUP-1:0]),
         .b     (src_b[GROUP-1:0]),
         .c_in  (src_c),
         .sum   (gsum),
         .c_out (gco),
         .grp_p (gp),
         .grp_g (gg)
      );

      // Group P/G are kept for a later two-level lookahead; not consumed here.
      assign unused_pg = gp ^ gg;

      // Merge this slice's sum bits and carry into the travelling record.
      always_comb begin
         nxt                          = prev;
         nxt.ctl.carry                = gco;
         nxt.psum[k*GROUP +: GROUP]   = gsum;
      end

      // Stage record register.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) rec <= '0;
         else if (en) rec <= nxt;
      end
   end

   // Output register: final result, carry-out and signed overflow, held while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (en) begin
         out_valid <= stg[NGRP-1].rec.ctl.valid;
         sum       <= stg[NGRP-1].rec.psum;
         cout      <= stg[NGRP-1].rec.ctl.carry;
         ovf       <= (stg[NGRP-1].rec.ctl.a_msb == stg[NGRP-1].rec.ctl.b_msb) &
                      (stg[NGRP-1].rec.psum[WIDTH-1] != stg[NGRP-1].rec.ctl.a_msb);
      end
   end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: three instances (GROUP 4, 16, 8) share operands;
// one instance is exercised at a time through a scoreboard queue.
module tb_cla_pipe_addsub;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
   } op_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } out_t;

   typedef struct {
      out_t o;
      int   acc;
   } sb_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b;
   logic         cin, sub;
   logic [2:0]   iv, ordy, ir, ov, co, of;
   logic [W-1:0] sm [3];

   int  checks = 0;
   int  passed = 0;
   int  cyc = 0;
   int  cur = 0;
   bit  lat_chk = 1'b1;
   bit  rmode = 1'b0;
   bit  gaps = 1'b0;
   bit  last_acc;
   int  lat [3] = '{4, 1, 2};
   sb_t sbq [$];
   op_t zop;
   out_t zout;
   vec_t tbl [8];

   always #5 clk = ~clk;

   cla_pipe_addsub #(.WIDTH(W), .GROUP(4)) u_g4 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]),
      .sum(sm[0]), .cout(co[0]), .ovf(of[0]));

   cla_pipe_addsub #(.WIDTH(W), .GROUP(16)) u_g16 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]),
      .sum(sm[1]), .cout(co[1]), .ovf(of[1]));

   cla_pipe_addsub #(.WIDTH(W), .GROUP(8)) u_g8 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]),
      .sum(sm[2]), .cout(co[2]), .ovf(of[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s (dut %0d, cycle %0d): got %h, expected %h", name, cur, cyc, act, exp);
   endtask

   function automatic out_t model(input op_t op);
      logic [W-1:0] bv;
      logic [W:0]   r;
      out_t         o;
      bv     = op.sub ? ~op.b : op.b;
      r      = {1'b0, op.a} + {1'b0, bv} + {{W{1'b0}}, (op.sub ? 1'b1 : op.cin)};
      o.sum  = r[W-1:0];
      o.cout = r[W];
      o.ovf  = (op.a[W-1] == bv[W-1]) && (r[W-1] != op.a[W-1]);
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t op;
      op.a   = W'($urandom);
      op.b   = W'($urandom);
      op.cin = 1'($urandom_range(0, 1));
      op.sub = 1'($urandom_range(0, 1));
      return op;
   endfunction

   function automatic bit pick_ready();
      return rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
   endfunction

   // One clock: drive at the falling edge, then observe handshakes before the rising edge.
   task automatic tick(input bit v, input op_t op, input bit r, input out_t e);
      sb_t s;
      @(negedge clk);
      cyc++;
      iv[cur]   = v;
      a         = op.a;
      b         = op.b;
      cin       = op.cin;
      sub       = op.sub;
      ordy[cur] = r;
      #1;
      if (ov[cur] && ordy[cur]) begin
         if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_output (dut %0d, cycle %0d): got sum %h, required no result", cur, cyc, sm[cur]);
         end else begin
            s = sbq.pop_front();
            check("result", 32'({sm[cur], co[cur], of[cur]}), 32'({s.o.sum, s.o.cout, s.o.ovf}));
            if (lat_chk) check("latency", 32'(cyc - s.acc - 1), 32'(lat[cur]));
         end
      end
      last_acc = iv[cur] && ir[cur] && !rst;
      if (last_acc) sbq.push_back('{e, cyc});
   endtask

   task automatic send(input op_t op, input out_t e);
      int n;
      if (gaps && $urandom_range(0, 2) == 0)
         repeat ($urandom_range(1, 3)) tick(1'b0, zop, pick_ready(), zout);
      n = 0;
      do begin
         tick(1'b1, op, pick_ready(), e);
         n++;
      end while (!last_acc && n < 200);
      if (!last_acc) begin
         checks++;
         $display("FAIL accept_timeout (dut %0d): got no accept in %0d cycles, required one", cur, n);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 300) begin
         tick(1'b0, zop, pick_ready(), zout);
         n++;
      end
      if (sbq.size() > 0) begin
         checks++;
         $display("FAIL drain_timeout (dut %0d): got %0d results outstanding, required 0", cur, sbq.size());
         sbq.delete();
      end
      repeat (3) tick(1'b0, zop, 1'b1, zout);
   endtask

   initial begin
      op_t          op;
      logic [W-1:0] held;

      zop  = '{16'h0, 16'h0, 1'b0, 1'b0};
      zout = '{16'h0, 1'b0, 1'b0};
      tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[6] = '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
      tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

      rst = 1'b1; iv = '0; ordy = '1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         cur = d;
         check("reset_outputs", 32'({ov[d], co[d], of[d], sm[d]}), 32'd0);
         check("reset_in_ready", 32'(ir[d]), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         cur = d;
         check("ready_after_reset", 32'(ir[d]), 32'd1);
      end

      // Directed vectors, isolated then back-to-back, on every slice size.
      for (int d = 0; d < 3; d++) begin
         cur = d; lat_chk = 1'b1; rmode = 1'b0; gaps = 1'b0;
         for (int i = 0; i < 8; i++) begin
            op = '{tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub};
            send(op, '{tbl[i].sum, tbl[i].cout, tbl[i].ovf});
            drain();
         end
         for (int i = 0; i < 8; i++) begin
            op = '{tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub};
            send(op, '{tbl[i].sum, tbl[i].cout, tbl[i].ovf});
         end
         drain();
         for (int i = 0; i < 20; i++) begin
            op = rand_op();
            send(op, model(op));
         end
         drain();
      end

      // Streaming: 100 mixed add/sub beats, one per cycle.
      cur = 0;
      for (int i = 0; i < 100; i++) begin
         op = rand_op();
         send(op, model(op));
      end
      drain();

      // Backpressure: five stalled cycles with a result waiting and a beat offered.
      lat_chk = 1'b0;
      for (int i = 0; i < 6; i++) begin
         op = rand_op();
         send(op, model(op));
      end
      op = rand_op();
      tick(1'b1, op, 1'b0, model(op));
      held = sm[0];
      check("stall_in_ready", 32'(ir[0]), 32'd0);
      check("stall_out_valid", 32'(ov[0]), 32'd1);
      for (int i = 1; i < 5; i++) begin
         tick(1'b1, op, 1'b0, model(op));
         check("stall_in_ready", 32'(ir[0]), 32'd0);
         check("stall_out_valid", 32'(ov[0]), 32'd1);
         check("stall_sum_frozen", 32'(sm[0]), 32'(held));
      end
      send(op, model(op));
      for (int i = 0; i < 4; i++) begin
         op = rand_op();
         send(op, model(op));
      end
      drain();

      // Random input gaps and random downstream readiness on every slice size.
      for (int d = 0; d < 3; d++) begin
         cur = d; rmode = 1'b1; gaps = 1'b1; lat_chk = 1'b0;
         for (int i = 0; i < 40; i++) begin
            op = rand_op();
            send(op, model(op));
         end
         drain();
      end

      // Reset with three operations in flight.
      cur = 0; rmode = 1'b0; gaps = 1'b0; lat_chk = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op = rand_op();
         send(op, model(op));
      end
      @(negedge clk);
      iv[0] = 1'b0;
      rst   = 1'b1;
      #1;
      check("midreset_out_valid", 32'(ov[0]), 32'd0);
      check("midreset_sum", 32'(sm[0]), 32'd0);
      check("midreset_in_ready", 32'(ir[0]), 32'd0);
      sbq.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) tick(1'b0, zop, 1'b1, zout);
      op = '{16'h00FF, 16'h0001, 1'b0, 1'b0};
      send(op, '{16'h0100, 1'b0, 1'b0});
      drain();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no end of test, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits a WIDTH-bit operation into GROUP-bit lookahead slices and registers between slices, so each clock covers one group's carry chain.
- Accepts one operation per cycle with valid/ready flow control. Emits sum, carry-out and signed overflow.
- Serves as the wide arithmetic datapath element for the ALU and accumulator paths.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per lookahead slice, which is one pipeline stage.
- NGRP, WIDTH/GROUP (derived localparam), number of slices; this is also the latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1: compute A - B, i.e. A + ~B + 1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB; for subtraction, 1 means no borrow.
- ovf  out  1  signed overflow.

Behaviour:
- Reset (async, rst=1): all stage valid bits cleared; out_valid=0, sum=0, cout=0, ovf=0. Registered data in all stages is cleared. in_ready=1 while rst=0 and the pipe is not stalled.
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Slice k (k = 0..NGRP-1) computes, in one cycle:
  - G = a_k & bb_k, P = a_k ^ bb_k.
  - Full lookahead carries inside the group, using no ripple.
  - sum_k = P ^ carries.
  - Group carry-out to the next stage.
- Skew: operand slices for groups k>0 are delayed k cycles in input skew registers. Result slices are de-skewed so that all WIDTH bits of one operation present together at the output.
- Stage 0 registers slice 0 results plus a carry register. Stage k consumes the stage-(k-1) carry.
- Latency: an operation accepted at edge t is presented with out_valid=1 after edge t+NGRP.
- Throughput: one operation per cycle when not stalled.
- Handshake:
  - en = !out_valid | out_ready; in_ready = en.
  - A transfer in occurs when in_valid & in_ready. A transfer out occurs when out_valid & out_ready.
  - When en=0, every pipeline register, valid bit and skew register holds; no data is lost or duplicated.
  - Bubbles (in_valid=0) propagate as invalid stages. Bubbles are not compressed.
  - out_valid is registered. sum/cout/ovf are stable while out_valid=1 and out_ready=0.
- ovf = (a[MSB] == bb[MSB]) & (sum[MSB] != a[MSB]). Evaluated in the last stage; needs a[MSB] and bb[MSB] carried alongside the final slice.
- cout = final group carry-out.
- sub and cin are sampled with the operands and travel with the operation; mixed add/sub back-to-back is legal.
- Overflow/wrap: sum is modulo 2^WIDTH.
- Degenerate case: NGRP=1 gives latency 1 with the same handshake.
- Elaboration error if WIDTH % GROUP != 0 or GROUP < 1.
- Reset mid-operation: every in-flight operation is discarded and no result is emitted for it. First new accept is possible the cycle after rst deasserts.
- in_valid while in_ready=0: the beat is not taken, and the source must hold it.

Decomposition:
- Shared package cla_pkg holds:
  - Default WIDTH/GROUP constants.
  - A function or constant computing NGRP.
  - A stage-record typedef {valid, sub, carry, a_msb, b_msb, partial sum}.
- Sub-module cla_group: combinational GROUP-bit lookahead slice. Inputs: a, b, c_in. Outputs: sum, c_out, grp_p, grp_g. Instantiated NGRP times inside a generate loop. grp_p/grp_g are exported for future two-level lookahead.

Test Plan:
- WIDTH=16, GROUP=4, out_ready=1. Single add a=0x00FF, b=0x0001, cin=0 -> after exactly 4 cycles: sum=0x0100, cout=0, ovf=0, out_valid for one cycle.
- Full carry ripple through all groups: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1.
- Subtract: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0 (borrow). sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
- Back-to-back streaming: 100 random ops with mixed sub, in_valid=1 every cycle -> one result per cycle, in order, all matching the reference model a±b.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 and outputs frozen. On release, results resume with no loss or duplicate. Random in_valid/out_ready gaps show the same behaviour.
- Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0 immediately, and none of the 3 ops ever appears. A post-reset op returns correctly after 4 cycles. Repeat the directed cases with GROUP=16 (NGRP=1, latency 1) and GROUP=8.
